seq_stage_controller: RTL

- Multi-cycle sequencer for the Y86-64 sequential core.
- Owns the architectural PC and steps fetch, decode, execute, memory and writeback one stage per enabled cycle.
- Computes the next PC from fetch, execute and memory results, and raises the processor status.
- Stops the machine on halt, invalid instruction or memory error.

---
 rtl/seq_stage_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/seq_stage_controller.sv
// seq_stage_controller
//   Multi-cycle sequencer for the Y86-64 sequential core. It owns the architectural PC and
//   steps fetch, decode, execute, memory, writeback and PC update, one stage per non-stalled
//   cycle (6 cycles per instruction). It latches the fetch, execute and memory results it
//   needs, computes the next PC, and stops the machine with a status code on halt, invalid
//   instruction or address error.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   stall             freezes the sequencer and forces every stage enable low
//   icode/valC/valP   fetch results, sampled in the decode state
//   in_mem/in_inst/hlt fetch fault and halt flags, sampled in the decode state
//   cnd               execute condition, sampled in the memory state
//   valM/dmem_error   data memory result and fault, sampled in the writeback state
//   pc                current architectural PC driven to fetch
//   *_en              one-hot stage enables
//   stat              1=AOK 2=HLT 3=ADR 4=INS
//   halted            machine stopped, waiting for reset
//   inst_count        retired instructions, wraps modulo 2^COUNT_W
module seq_stage_controller #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [3:0]         icode,
  input  logic [63:0]        valC,
  input  logic [63:0]        valP,
  input  logic               in_mem,
  input  logic               in_inst,
  input  logic               hlt,
  input  logic               cnd,
  input  logic [63:0]        valM,
  input  logic               dmem_error,
  output logic [63:0]        pc,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               exec_en,
  output logic               mem_en,
  output logic               wb_en,
  output logic [2:0]         stat,
  output logic               halted,
  output logic [COUNT_W-1:0] inst_count
);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;

  localparam logic [3:0] IcodeHalt = 4'h0;
  localparam logic [3:0] IcodeJxx  = 4'h7;
  localparam logic [3:0] IcodeCall = 4'h8;
  localparam logic [3:0] IcodeRet  = 4'h9;
  localparam logic [3:0] IcodeMax  = 4'hB;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StPcUpdate,
    StHalt
  } state_e;

  state_e               state_q, state_d;
  logic [63:0]          pc_q, pc_d;
  logic [2:0]           stat_q, stat_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [3:0]           icode_q, icode_d;
  logic [63:0]          valc_q, valc_d;
  logic [63:0]          valp_q, valp_d;
  logic                 cnd_q, cnd_d;
  logic [63:0]          valm_q, valm_d;

  logic [63:0]          new_pc;
  logic                 mem_access;

  // Instructions that touch data memory; only these can raise a data address error.
  assign mem_access = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  always_comb begin
    new_pc = valp_q;
    if (icode_q == IcodeCall || (icode_q == IcodeJxx && cnd_q)) begin
      new_pc = valc_q;
    end else if (icode_q == IcodeRet) begin
      new_pc = valm_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    count_d = count_q;
    icode_d = icode_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    cnd_d   = cnd_q;
    valm_d  = valm_q;

    if (!stall) begin
      unique case (state_q)
        StFetch: state_d = StDecode;

        StDecode: begin
          icode_d = icode;
          valc_d  = valC;
          valp_d  = valP;
          // Priority: fetch address error, then invalid instruction, then halt.
          if (in_mem) begin
            stat_d  = StatAdr;
            state_d = StHalt;
          end else if (in_inst || icode > IcodeMax) begin
            stat_d  = StatIns;
            state_d = StHalt;
          end else if (hlt || icode == IcodeHalt) begin
            stat_d  = StatHlt;
            state_d = StHalt;
          end else begin
            state_d = StExecute;
          end
        end

        StExecute: state_d = StMemory;

        StMemory: begin
          cnd_d   = cnd;
          state_d = StWriteback;
        end

        StWriteback: begin
          valm_d = valM;
          if (dmem_error && mem_access) begin
            stat_d  = StatAdr;
            state_d = StHalt;
          end else begin
            state_d = StPcUpdate;
          end
        end

        StPcUpdate: begin
          pc_d    = new_pc;
          count_d = count_q + COUNT_W'(1);
          state_d = StFetch;
        end

        // Terminal until reset; PC, status and count stay frozen.
        StHalt: state_d = StHalt;

        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      stat_q  <= StatAok;
      count_q <= '0;
      icode_q <= '0;
      valc_q  <= '0;
      valp_q  <= '0;
      cnd_q   <= 1'b0;
      valm_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      count_q <= count_d;
      icode_q <= icode_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      cnd_q   <= cnd_d;
      valm_q  <= valm_d;
    end
  end

  // Enables decode the state directly so fetch_en is already high while in reset.
  assign fetch_en   = !stall && (state_q == StFetch);
  assign decode_en  = !stall && (state_q == StDecode);
  assign exec_en    = !stall && (state_q == StExecute);
  assign mem_en     = !stall && (state_q == StMemory);
  assign wb_en      = !stall && (state_q == StWriteback);

  assign pc         = pc_q;
  assign stat       = stat_q;
  assign halted     = (state_q == StHalt);
  assign inst_count = count_q;

endmodule
